// File: rtl/boot_reset_ctrl_if.sv
// boot_reset_ctrl_if: request/config inputs and reset/watchdog outputs of the reset sequencer
interface boot_reset_ctrl_if #(parameter int CNT_W = 8);
  logic tick_10hz_fp;
  logic req_cold_boot;
  logic req_warm_boot;
  logic wdg_timeout;
  logic cfg_wdg_cold;
  logic sw_wdg_arm;
  logic wdg_en;
  logic warm_reset_out;
  logic power_cycle_en;
  logic busy;
  logic [1:0] last_cause;
  logic [CNT_W-1:0] reset_count;
  modport master (
    output tick_10hz_fp, req_cold_boot, req_warm_boot, wdg_timeout, cfg_wdg_cold, sw_wdg_arm,
    input wdg_en, warm_reset_out, power_cycle_en, busy, last_cause, reset_count
  );
  modport slave (
    input tick_10hz_fp, req_cold_boot, req_warm_boot, wdg_timeout, cfg_wdg_cold, sw_wdg_arm,
    output wdg_en, warm_reset_out, power_cycle_en, busy, last_cause, reset_count
  );
endinterface

// File: rtl/boot_reset_ctrl.sv
// boot_reset_ctrl: arbitrates cold/warm/watchdog resets, holds them for tick counts, then a watchdog holdoff; ports clk, rst, bus (boot_reset_ctrl_if.slave)
module boot_reset_ctrl #(
  parameter int WARM_HOLD_TICKS = 5,
  parameter int COLD_HOLD_TICKS = 20,
  parameter int HOLDOFF_TICKS = 30,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  boot_reset_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WARM, COLD, HOLDOFF} state_t;
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM_HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] COLD_LAST = CNT_W'(COLD_HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_TICKS - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d, last_tick;
  logic [1:0] cause_q, cause_d;
  logic wdg_en_q, wdg_en_d, warm_q, warm_d, pwr_q, pwr_d, busy_q, busy_d, bump;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cause_d = cause_q;
    bump = 1'b0;
    last_tick = state_q == WARM ? WARM_LAST : state_q == COLD ? COLD_LAST : HOLD_LAST;
    case (state_q)
      IDLE: begin
        if (bus.req_cold_boot) begin
          state_d = COLD;
          cause_d = 2'd2;
          bump = 1'b1;
        end else if (bus.wdg_timeout && wdg_en_q) begin
          state_d = bus.cfg_wdg_cold ? COLD : WARM;
          cause_d = 2'd3;
          bump = 1'b1;
        end else if (bus.req_warm_boot) begin
          state_d = WARM;
          cause_d = 2'd1;
          bump = 1'b1;
        end
      end
      default: begin
        if (bus.req_cold_boot && state_q != COLD) begin
          state_d = COLD;
          cause_d = 2'd2;
          bump = 1'b1;
        end else if (bus.tick_10hz_fp) begin
          cnt_d = cnt_q == last_tick ? '0 : cnt_q + 1'b1;
          state_d = cnt_q != last_tick ? state_q : state_q == HOLDOFF ? IDLE : HOLDOFF;
        end
      end
    endcase
    if (bump) cnt_d = '0;
    rcnt_d = (bump && rcnt_q != '1) ? rcnt_q + 1'b1 : rcnt_q;
    wdg_en_d = state_d == IDLE && bus.sw_wdg_arm;
    warm_d = state_d == WARM || state_d == COLD;
    pwr_d = state_d == COLD;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rcnt_q <= '0;
      cause_q <= 2'd0;
      wdg_en_q <= 1'b0;
      warm_q <= 1'b0;
      pwr_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rcnt_q <= rcnt_d;
      cause_q <= cause_d;
      wdg_en_q <= wdg_en_d;
      warm_q <= warm_d;
      pwr_q <= pwr_d;
      busy_q <= busy_d;
    end
  end
  assign bus.wdg_en = wdg_en_q;
  assign bus.warm_reset_out = warm_q;
  assign bus.power_cycle_en = pwr_q;
  assign bus.busy = busy_q;
  assign bus.last_cause = cause_q;
  assign bus.reset_count = rcnt_q;
endmodule

// File: tb/tb_boot_reset_ctrl.sv
// tb_boot_reset_ctrl: directed checks of the reset sequencer with 3/5/4 tick holds and a tick every 10 clocks
module tb_boot_reset_ctrl;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  int tcnt = 0;
  int wt = 0, pt = 0, ht = 0;
  int wb, pb, hb;
  boot_reset_ctrl_if #(.CNT_W(8)) bus ();
  boot_reset_ctrl #(.WARM_HOLD_TICKS(3), .COLD_HOLD_TICKS(5), .HOLDOFF_TICKS(4), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    tcnt <= tcnt == 9 ? 0 : tcnt + 1;
    bus.tick_10hz_fp <= tcnt == 8;
  end
  always @(posedge clk) begin
    if (bus.tick_10hz_fp === 1'b1) begin
      if (bus.warm_reset_out === 1'b1) wt <= wt + 1;
      if (bus.power_cycle_en === 1'b1) pt <= pt + 1;
      if (bus.busy === 1'b1 && bus.warm_reset_out === 1'b0) ht <= ht + 1;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && bus.busy !== 1'b0; i++) cyc(1);
    chk(tag, {31'd0, bus.busy}, 32'd0);
  endtask
  task automatic pulse_warm();
    bus.req_warm_boot = 1'b1;
    cyc(1);
    bus.req_warm_boot = 1'b0;
  endtask
  task automatic pulse_cold();
    bus.req_cold_boot = 1'b1;
    cyc(1);
    bus.req_cold_boot = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.req_cold_boot = 1'b0;
    bus.req_warm_boot = 1'b0;
    bus.wdg_timeout = 1'b0;
    bus.cfg_wdg_cold = 1'b0;
    bus.sw_wdg_arm = 1'b0;
    cyc(5);
    chk("rst_wdg_en", {31'd0, bus.wdg_en}, 0);
    chk("rst_warm", {31'd0, bus.warm_reset_out}, 0);
    chk("rst_pwr", {31'd0, bus.power_cycle_en}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_cause", {30'd0, bus.last_cause}, 0);
    chk("rst_count", {24'd0, bus.reset_count}, 0);
    rst = 1'b0;
    bus.sw_wdg_arm = 1'b1;
    cyc(1);
    chk("arm_wdg_en", {31'd0, bus.wdg_en}, 1);
    wb = wt; hb = ht;
    pulse_warm();
    chk("warm_busy", {31'd0, bus.busy}, 1);
    chk("warm_out", {31'd0, bus.warm_reset_out}, 1);
    chk("warm_pwr", {31'd0, bus.power_cycle_en}, 0);
    chk("warm_wdg_en", {31'd0, bus.wdg_en}, 0);
    chk("warm_cause", {30'd0, bus.last_cause}, 1);
    chk("warm_count", {24'd0, bus.reset_count}, 1);
    wait_idle("warm_idle");
    chk("warm_ticks", wt - wb, 3);
    chk("warm_holdoff", ht - hb, 4);
    chk("warm_rearm", {31'd0, bus.wdg_en}, 1);
    bus.cfg_wdg_cold = 1'b1;
    bus.wdg_timeout = 1'b1;
    wb = wt; pb = pt;
    cyc(1);
    bus.sw_wdg_arm = 1'b0;
    chk("wdg_pwr", {31'd0, bus.power_cycle_en}, 1);
    chk("wdg_warm", {31'd0, bus.warm_reset_out}, 1);
    chk("wdg_cause", {30'd0, bus.last_cause}, 3);
    chk("wdg_count", {24'd0, bus.reset_count}, 2);
    wait_idle("wdg_idle");
    chk("wdg_pwr_ticks", pt - pb, 5);
    chk("wdg_warm_ticks", wt - wb, 5);
    cyc(30);
    chk("wdg_stale_busy", {31'd0, bus.busy}, 0);
    chk("wdg_stale_count", {24'd0, bus.reset_count}, 2);
    chk("wdg_stale_en", {31'd0, bus.wdg_en}, 0);
    bus.wdg_timeout = 1'b0;
    bus.cfg_wdg_cold = 1'b0;
    bus.sw_wdg_arm = 1'b1;
    cyc(1);
    bus.req_cold_boot = 1'b1;
    bus.req_warm_boot = 1'b1;
    cyc(1);
    bus.req_cold_boot = 1'b0;
    bus.req_warm_boot = 1'b0;
    chk("prio_pwr", {31'd0, bus.power_cycle_en}, 1);
    chk("prio_cause", {30'd0, bus.last_cause}, 2);
    chk("prio_count", {24'd0, bus.reset_count}, 3);
    wait_idle("prio_idle");
    pulse_warm();
    chk("esc_warm_pwr", {31'd0, bus.power_cycle_en}, 0);
    chk("esc_warm_count", {24'd0, bus.reset_count}, 4);
    for (int i = 0; i < 20 && bus.tick_10hz_fp !== 1'b1; i++) cyc(1);
    cyc(1);
    pb = pt;
    pulse_cold();
    chk("esc_pwr", {31'd0, bus.power_cycle_en}, 1);
    chk("esc_cause", {30'd0, bus.last_cause}, 2);
    chk("esc_count", {24'd0, bus.reset_count}, 5);
    wait_idle("esc_idle");
    chk("esc_pwr_ticks", pt - pb, 5);
    pulse_warm();
    for (int i = 0; i < 100 && bus.warm_reset_out !== 1'b0; i++) cyc(1);
    chk("hold_busy", {31'd0, bus.busy}, 1);
    pulse_warm();
    chk("hold_warm_drop_out", {31'd0, bus.warm_reset_out}, 0);
    chk("hold_warm_drop_count", {24'd0, bus.reset_count}, 6);
    pulse_cold();
    chk("hold_cold_pwr", {31'd0, bus.power_cycle_en}, 1);
    chk("hold_cold_count", {24'd0, bus.reset_count}, 7);
    wait_idle("hold_cold_idle");
    for (int n = 0; n < 260; n++) begin
      pulse_warm();
      for (int i = 0; i < 300 && bus.busy !== 1'b0; i++) cyc(1);
    end
    chk("sat_busy", {31'd0, bus.busy}, 0);
    chk("sat_count", {24'd0, bus.reset_count}, 255);
    chk("sat_cause", {30'd0, bus.last_cause}, 1);
    pulse_cold();
    chk("midrst_pwr_pre", {31'd0, bus.power_cycle_en}, 1);
    chk("midrst_count_pre", {24'd0, bus.reset_count}, 255);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk("midrst_pwr", {31'd0, bus.power_cycle_en}, 0);
    chk("midrst_warm", {31'd0, bus.warm_reset_out}, 0);
    chk("midrst_busy", {31'd0, bus.busy}, 0);
    chk("midrst_cause", {30'd0, bus.last_cause}, 0);
    chk("midrst_count", {24'd0, bus.reset_count}, 0);
    chk("midrst_wdg_en", {31'd0, bus.wdg_en}, 0);
    rst = 1'b0;
    cyc(2);
    chk("post_rst_wdg_en", {31'd0, bus.wdg_en}, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
